// File: rtl/trigger_arm_fsm_if.sv
// Arm/trigger control and status bundle for the ADC capture trigger FSM.
// Each control is a level sampled on adc_sampleclk; capture_go is a one-cycle pulse and has no ready/ack.
interface trigger_arm_fsm_if;
  logic        cmd_arm_adc;
  logic        trigger_mode;
  logic        trigger_wait;
  logic        trigger_now;
  logic        data_source_select;
  logic [11:0] adc_data;
  logic [11:0] trigger_adclevel;
  logic        trig_in;
  logic [31:0] trigger_offset;
  logic        capture_go;
  logic        armed_o;
  logic [31:0] trigger_length;
  logic [2:0]  state_o;

  modport master (
    output cmd_arm_adc, trigger_mode, trigger_wait, trigger_now,
           data_source_select, adc_data, trigger_adclevel, trig_in, trigger_offset,
    input  capture_go, armed_o, trigger_length, state_o
  );

  modport slave (
    input  cmd_arm_adc, trigger_mode, trigger_wait, trigger_now,
           data_source_select, adc_data, trigger_adclevel, trig_in, trigger_offset,
    output capture_go, armed_o, trigger_length, state_o
  );
endinterface

// File: rtl/trigger_arm_fsm.sv
// Arms on a rising edge of cmd_arm_adc, waits for a digital or ADC-level trigger,
// delays by trigger_offset cycles and emits one capture_go pulse per arm.
module trigger_arm_fsm (
  input  logic                    adc_sampleclk,
  input  logic                    reset_n,
  trigger_arm_fsm_if.slave        trg
);

  typedef enum logic [2:0] {
    S_IDLE          = 3'd0,
    S_WAIT_INACTIVE = 3'd1,
    S_ARMED         = 3'd2,
    S_OFFSET        = 3'd3,
    S_DONE          = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        trig_raw, trig_r;
  logic        arm_d, rst_mask, arm_rise, trig_event;
  logic [31:0] offset_cnt_q, offset_cnt_d;
  logic [31:0] trig_len_q;
  logic        len_run_q;
  logic        go_q, go_d;
  logic        len_clear, len_start;

  always_comb begin
    trig_raw = 1'b0;
    if (trg.data_source_select) begin
      if (trg.trigger_mode) trig_raw = (trg.adc_data >= trg.trigger_adclevel);
      else                  trig_raw = (trg.adc_data <  trg.trigger_adclevel);
    end else begin
      trig_raw = (trg.trig_in == trg.trigger_mode);
    end
  end

  // rst_mask hides a cmd_arm_adc that is already high when reset releases.
  assign arm_rise   = trg.cmd_arm_adc & ~arm_d & ~rst_mask;
  assign trig_event = trig_r | trg.trigger_now;

  always_comb begin
    state_d      = state_q;
    offset_cnt_d = offset_cnt_q;
    go_d         = 1'b0;
    len_clear    = 1'b0;
    len_start    = 1'b0;
    if (!trg.cmd_arm_adc) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arm_rise) begin
            state_d   = trg.trigger_wait ? S_WAIT_INACTIVE : S_ARMED;
            len_clear = 1'b1;
          end
        end
        S_WAIT_INACTIVE: begin
          if (!trig_r) state_d = S_ARMED;
        end
        S_ARMED: begin
          if (trig_event) begin
            len_start = 1'b1;
            if (trg.trigger_offset == 32'd0) begin
              go_d    = 1'b1;
              state_d = S_DONE;
            end else begin
              offset_cnt_d = trg.trigger_offset;
              state_d      = S_OFFSET;
            end
          end
        end
        S_OFFSET: begin
          offset_cnt_d = offset_cnt_q - 32'd1;
          if (offset_cnt_q == 32'd1) begin
            go_d    = 1'b1;
            state_d = S_DONE;
          end
        end
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge adc_sampleclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      offset_cnt_q <= 32'd0;
      go_q         <= 1'b0;
      trig_r       <= 1'b0;
      arm_d        <= 1'b0;
      rst_mask     <= 1'b1;
    end else begin
      state_q      <= state_d;
      offset_cnt_q <= offset_cnt_d;
      go_q         <= go_d;
      trig_r       <= trig_raw;
      arm_d        <= trg.cmd_arm_adc;
      rst_mask     <= 1'b0;
    end
  end

  // Length of the trig_r=1 run that begins on the trigger-event cycle; freezes on the first low.
  always_ff @(posedge adc_sampleclk or negedge reset_n) begin
    if (!reset_n) begin
      trig_len_q <= 32'd0;
      len_run_q  <= 1'b0;
    end else if (len_clear) begin
      trig_len_q <= 32'd0;
      len_run_q  <= 1'b0;
    end else if (len_start) begin
      trig_len_q <= {31'd0, trig_r};
      len_run_q  <= trig_r;
    end else if (((state_q == S_OFFSET) || (state_q == S_DONE)) && len_run_q) begin
      if (trig_r) begin
        if (trig_len_q != 32'hFFFF_FFFF) trig_len_q <= trig_len_q + 32'd1;
      end else begin
        len_run_q <= 1'b0;
      end
    end
  end

  assign trg.capture_go     = go_q;
  assign trg.armed_o        = (state_q == S_WAIT_INACTIVE) || (state_q == S_ARMED) ||
                              (state_q == S_OFFSET);
  assign trg.trigger_length = trig_len_q;
  assign trg.state_o        = state_q;

endmodule

// File: tb/tb_trigger_arm_fsm.sv
// Directed bench for trigger_arm_fsm: a cycle-timed behavioural model checked every cycle,
// plus literal expectations on capture timing, status and trigger length.
module tb_trigger_arm_fsm;

  localparam int P_IDLE = 0, P_WAIT = 1, P_ARMED = 2, P_OFFSET = 3, P_DONE = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  trigger_arm_fsm_if bus ();

  trigger_arm_fsm dut (
    .adc_sampleclk (clk),
    .reset_n       (reset_n),
    .trg           (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic trig_of(input logic dss, input logic mode, input logic [11:0] adc,
                                   input logic [11:0] lvl, input logic tin);
    if (dss) return mode ? (adc >= lvl) : (adc < lvl);
    return tin == mode;
  endfunction

  // Model: tracks the arm phase and the absolute cycle at which capture_go must appear.
  int unsigned cyc = 0;
  int          m_phase;
  logic        m_trig_r, m_arm_d, m_mask, m_go, m_run;
  logic [31:0] m_len;
  longint      m_fire_at;
  int          ph;
  logic        rise, ev;
  int          preload_req = 0, preload_ack = 0;
  logic [31:0] preload_val = 32'd0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase = P_IDLE; m_trig_r = 1'b0; m_arm_d = 1'b0; m_mask = 1'b1;
      m_go = 1'b0; m_run = 1'b0; m_len = 32'd0; m_fire_at = 0;
    end else begin
      cyc++;
      if (preload_req != preload_ack) begin
        m_len = preload_val;
        preload_ack = preload_req;
      end
      ph   = m_phase;
      rise = bus.cmd_arm_adc && !m_arm_d && !m_mask;
      ev   = (ph == P_ARMED) && (m_trig_r || bus.trigger_now);
      m_go = 1'b0;
      if ((ph == P_OFFSET || ph == P_DONE) && m_run) begin
        if (m_trig_r) begin
          if (m_len != 32'hFFFF_FFFF) m_len = m_len + 32'd1;
        end else m_run = 1'b0;
      end
      if (!bus.cmd_arm_adc) m_phase = P_IDLE;
      else if (ph == P_IDLE && rise) begin
        m_phase = bus.trigger_wait ? P_WAIT : P_ARMED;
        m_len = 32'd0; m_run = 1'b0;
      end else if (ph == P_WAIT && !m_trig_r) m_phase = P_ARMED;
      else if (ev) begin
        m_len = {31'd0, m_trig_r}; m_run = m_trig_r;
        if (bus.trigger_offset == 32'd0) begin m_go = 1'b1; m_phase = P_DONE; end
        else begin m_fire_at = longint'(cyc) + longint'(bus.trigger_offset); m_phase = P_OFFSET; end
      end else if (ph == P_OFFSET && longint'(cyc) == m_fire_at) begin
        m_go = 1'b1; m_phase = P_DONE;
      end
      m_trig_r = trig_of(bus.data_source_select, bus.trigger_mode, bus.adc_data,
                         bus.trigger_adclevel, bus.trig_in);
      m_arm_d = bus.cmd_arm_adc;
      m_mask  = 1'b0;
    end
  end

  int          go_count = 0;
  int unsigned go_cyc = 0;

  always @(posedge clk) begin
    #1;
    check("capture_go", {31'd0, bus.capture_go}, {31'd0, m_go});
    check("armed_o", {31'd0, bus.armed_o},
          {31'd0, (m_phase == P_WAIT || m_phase == P_ARMED || m_phase == P_OFFSET)});
    check("state_o", {29'd0, bus.state_o}, m_phase);
    check("trigger_length", bus.trigger_length, m_len);
    if (bus.capture_go === 1'b1) begin
      go_count++;
      go_cyc = cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic setup(input logic dss, input logic mode, input logic wt,
                       input logic [31:0] off, input logic tin);
    bus.data_source_select = dss; bus.trigger_mode = mode; bus.trigger_wait = wt;
    bus.trigger_offset = off; bus.trig_in = tin; bus.trigger_now = 1'b0;
  endtask

  int unsigned n0;
  int          g0;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_arm_adc = 1'b1; bus.trigger_mode = 1'b0; bus.trigger_wait = 1'b0;
    bus.trigger_now = 1'b0; bus.data_source_select = 1'b0; bus.adc_data = 12'd0;
    bus.trigger_adclevel = 12'd0; bus.trig_in = 1'b0; bus.trigger_offset = 32'd0;
    tick(3);
    check("reset_state", {29'd0, bus.state_o}, 32'd0);
    check("reset_length", bus.trigger_length, 32'd0);
    reset_n = 1'b1;
    tick(4);
    check("arm_high_at_reset_release", {29'd0, bus.state_o}, P_IDLE);
    bus.cmd_arm_adc = 1'b0;
    tick(2);

    // Digital trigger, offset 0
    setup(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    bus.cmd_arm_adc = 1'b1;
    tick(3);
    check("digital_armed_state", {29'd0, bus.state_o}, P_ARMED);
    g0 = go_count; n0 = cyc;
    bus.trig_in = 1'b1;
    tick(4);
    check("digital_go_cycle", go_cyc, n0 + 2);
    check("digital_go_count", go_count, g0 + 1);
    check("digital_done_state", {29'd0, bus.state_o}, P_DONE);
    bus.cmd_arm_adc = 1'b0; bus.trig_in = 1'b0;
    tick(2);
    check("digital_back_idle", {29'd0, bus.state_o}, P_IDLE);

    // ADC >= level with offset 5, offset changed after load, 37-cycle trigger run
    setup(1'b1, 1'b1, 1'b0, 32'd5, 1'b0);
    bus.trigger_adclevel = 12'h800; bus.adc_data = 12'h7FF;
    bus.cmd_arm_adc = 1'b1;
    tick(3);
    g0 = go_count; n0 = cyc;
    bus.adc_data = 12'h800;
    tick(2);
    bus.trigger_offset = 32'd50;
    tick(2);
    check("offset_state", {29'd0, bus.state_o}, P_OFFSET);
    tick(33);
    bus.adc_data = 12'h7FF;
    tick(3);
    check("offset_go_cycle", go_cyc, n0 + 7);
    check("offset_go_count", go_count, g0 + 1);
    check("length_37", bus.trigger_length, 32'd37);
    bus.cmd_arm_adc = 1'b0;
    tick(2);

    // Wait-inactive: trigger already active at arm, trigger_now must not bypass
    setup(1'b0, 1'b1, 1'b1, 32'd0, 1'b1);
    bus.cmd_arm_adc = 1'b1;
    g0 = go_count;
    tick(3);
    bus.trigger_now = 1'b1;
    tick(3);
    check("wait_state", {29'd0, bus.state_o}, P_WAIT);
    check("wait_no_go", go_count, g0);
    bus.trigger_now = 1'b0; bus.trig_in = 1'b0;
    tick(3);
    check("wait_to_armed", {29'd0, bus.state_o}, P_ARMED);
    bus.trig_in = 1'b1;
    tick(4);
    check("wait_go_count", go_count, g0 + 1);
    bus.cmd_arm_adc = 1'b0; bus.trig_in = 1'b0;
    tick(2);

    // Abort in OFFSET via trigger_now with trig_r low
    setup(1'b0, 1'b1, 1'b0, 32'd100, 1'b0);
    bus.cmd_arm_adc = 1'b1;
    tick(3);
    g0 = go_count;
    bus.trigger_now = 1'b1;
    tick(3);
    bus.trigger_now = 1'b0;
    check("abort_offset_state", {29'd0, bus.state_o}, P_OFFSET);
    check("abort_armed", {31'd0, bus.armed_o}, 32'd1);
    check("now_length_zero", bus.trigger_length, 32'd0);
    bus.cmd_arm_adc = 1'b0;
    tick(1);
    check("abort_idle", {29'd0, bus.state_o}, P_IDLE);
    check("abort_armed_low", {31'd0, bus.armed_o}, 32'd0);
    tick(110);
    check("abort_no_go", go_count, g0);

    // Saturation of trigger_length with a forced preload
    setup(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
    bus.cmd_arm_adc = 1'b1;
    tick(5);
    force dut.trig_len_q = 32'hFFFF_FFFD;
    preload_val = 32'hFFFF_FFFD;
    preload_req++;
    #1 release dut.trig_len_q;
    tick(5);
    check("length_saturated", bus.trigger_length, 32'hFFFF_FFFF);
    bus.cmd_arm_adc = 1'b0; bus.trig_in = 1'b0;
    tick(2);

    // Async reset mid-OFFSET, then no capture until a fresh arm edge
    setup(1'b0, 1'b1, 1'b0, 32'd100, 1'b1);
    bus.cmd_arm_adc = 1'b1;
    tick(5);
    check("pre_reset_offset", {29'd0, bus.state_o}, P_OFFSET);
    #1 reset_n = 1'b0;
    #1;
    check("async_capture_go", {31'd0, bus.capture_go}, 32'd0);
    check("async_armed", {31'd0, bus.armed_o}, 32'd0);
    check("async_length", bus.trigger_length, 32'd0);
    check("async_state", {29'd0, bus.state_o}, 32'd0);
    g0 = go_count;
    tick(2);
    reset_n = 1'b1;
    tick(10);
    check("post_reset_idle", {29'd0, bus.state_o}, P_IDLE);
    check("post_reset_no_go", go_count, g0);
    bus.cmd_arm_adc = 1'b0;
    tick(2);
    bus.trigger_offset = 32'd0;
    bus.cmd_arm_adc = 1'b1;
    tick(3);
    check("rearm_go", go_count, g0 + 1);
    bus.cmd_arm_adc = 1'b0; bus.trig_in = 1'b0;
    tick(2);

    // ADC < level with wait, equality is not a trigger, offset 1
    setup(1'b1, 1'b0, 1'b1, 32'd1, 1'b0);
    bus.trigger_adclevel = 12'h100; bus.adc_data = 12'h100;
    bus.cmd_arm_adc = 1'b1;
    tick(4);
    check("adc_lt_armed", {29'd0, bus.state_o}, P_ARMED);
    g0 = go_count; n0 = cyc;
    bus.adc_data = 12'h0FF;
    tick(5);
    check("adc_lt_go_cycle", go_cyc, n0 + 3);
    check("adc_lt_go_count", go_count, g0 + 1);
    bus.cmd_arm_adc = 1'b0;
    tick(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
